alu_seq_unit: RTL
=================

Name: alu_seq_unit

Overview:
- Sequential, handshaked ALU execution unit.
- Responder side of the x/y/opcode operation interface: accepts one operation per request handshake and returns o/product/remainder plus flags on a response handshake.
- Logic, add and shift ops complete in one cycle; MUL uses iterative shift-add and DIV uses iterative restoring division.
- Sits between an operation issuer (sequencer or test driver) and a result consumer.

Parameters:
- WIDTH, 4, operand width; o and remainder are WIDTH bits, product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  1  issuer presents x, y, opcode.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- opcode  input  4  operation select.
- rsp_valid  output  1  result registers valid.
- rsp_ready  input  1  consumer accepts the result.
- o  output  WIDTH  primary result; quotient for DIV.
- product  output  2*WIDTH  MUL result; 0 for all other ops.
- remainder  output  WIDTH  DIV remainder; 0 for all other ops.
- carry  output  1  ADD carry-out; SUB borrow (x<y); 0 otherwise.
- zero  output  1  result==0: product for MUL, o for all other ops.
- err  output  1  illegal opcode or divide-by-zero.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream): state=IDLE; o, product, remainder, carry, zero, err, rsp_valid = 0; req_ready=1. Asserting rst_n mid-operation aborts the operation and discards all results.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch x, y, opcode. MUL/DIV go to EXEC; all other opcodes compute and go to DONE.
  - EXEC: iteration counter runs 0..WIDTH-1, one iteration per cycle; after the final iteration go to DONE.
  - DONE: rsp_valid=1; all outputs held stable. On rsp_ready go to IDLE.
- Latency (request handshake edge to rsp_valid): 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL/DIV (5 for WIDTH=4).
- Throughput: no overlap; req_ready is low from accept until the cycle after the response handshake. rsp_valid holds indefinitely under backpressure.
- Opcodes, all results modulo 2^WIDTH unless noted:
  - 0000 NOT: o = ~x.
  - 0001 AND: o = x&y.
  - 0010 NAND: o = ~(x&y).
  - 0011 OR: o = x|y.
  - 0100 NOR: o = ~(x|y).
  - 0101 XOR: o = x^y.
  - 0110 XNOR: o = ~(x^y).
  - 0111 SHIFT: o = x<<y, logical; o=0 when y>=WIDTH.
  - 1000 ADD: {carry,o} = x+y.
  - 1001 SUB: o = x-y; carry=1 when x<y.
  - 1010 MUL: product = x*y, unsigned; o = product[WIDTH-1:0].
  - 1011 DIV: o = x/y, remainder = x%y, unsigned.
  - 1100-1111: illegal; o=0, err=1, 1-cycle latency.
- Divide by zero: completes the full WIDTH+1 latency; o = all ones, remainder = x, err=1.
- Inputs x, y, opcode changing after acceptance have no effect on the operation in flight.
- The response handshake and a new req_valid in the same cycle: the request is not accepted that cycle, because req_ready=0 in DONE.

Test Plan:
- Reset then idle: rst_n low for 2 cycles → all outputs 0, req_ready=1, rsp_valid=0. Pulse rst_n low while in EXEC (MUL) → state IDLE immediately, rsp_valid=0.
- Logic sweep, WIDTH=4: NOT x=0000 → o=1111; AND 0000/1111 → 0000; NAND → 1111; OR → 1111; NOR → 0000; XOR → 1111; XNOR 0000/0000 → 1111. Each with rsp_valid exactly 1 cycle after accept; zero flag checked on every result.
- Arithmetic: ADD 0000+1111 → o=1111, carry=0; ADD 1111+0001 → o=0000, carry=1, zero=1; SUB 0000-1111 → o=0001, carry=1; SHIFT 0011<<0010 → 1100; SHIFT x<<0100 → 0000.
- MUL 1111*1111: product=11100001, o=0001, rsp_valid exactly 5 cycles after accept, req_ready=0 throughout.
- DIV: 1111/1111 → o=0001, remainder=0000, zero=0; 1111/0100 → o=0011, remainder=0011; 1010/0000 → o=1111, remainder=1010, err=1; each with 5-cycle latency.
- Backpressure and illegal opcode: hold rsp_ready=0 for 10 cycles with req_valid=1 and changing inputs → outputs stable, no new accept; release → IDLE next cycle, then next request accepted. Opcode 1110 → o=0, err=1.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Sequential handshaked ALU execution unit.
// Logic, add, sub, shift and illegal opcodes resolve on the accept edge.
// MUL runs an iterative shift-add and DIV runs an iterative restoring divide.
// Each of those takes WIDTH iterations.
// All response outputs are registers and stay stable while rsp_valid is high.
module alu_seq_unit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [3:0]         opcode,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   o,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   remainder,
  output logic               carry,
  output logic               zero,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH + 1)'(WIDTH);

  localparam logic [3:0] OP_NOT   = 4'b0000;
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_NAND  = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_XNOR  = 4'b0110;
  localparam logic [3:0] OP_SHIFT = 4'b0111;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     x_q;
  logic [WIDTH-1:0]     y_q;
  logic [3:0]           op_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     rem_q;

  logic [WIDTH-1:0]     o_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [WIDTH-1:0]     remainder_q;
  logic                 carry_q;
  logic                 zero_q;
  logic                 err_q;
  logic                 rsp_valid_q;
  logic                 req_ready_q;

  // Single-cycle result, evaluated directly from the request inputs
  logic [WIDTH-1:0]     sc_o_d;
  logic                 sc_carry_d;
  logic                 sc_err_d;
  logic [WIDTH:0]       sum_d;

  // Iterative datapath: next values for one MUL / DIV step
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH:0]       rem_sh_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quo_d;

  // Decode and compute the one-cycle operations from the live request
  always_comb begin
    sc_o_d     = {WIDTH{1'b0}};
    sc_carry_d = 1'b0;
    sc_err_d   = 1'b0;
    sum_d      = {1'b0, x} + {1'b0, y};
    case (opcode)
      OP_NOT:   sc_o_d = ~x;
      OP_AND:   sc_o_d = x & y;
      OP_NAND:  sc_o_d = ~(x & y);
      OP_OR:    sc_o_d = x | y;
      OP_NOR:   sc_o_d = ~(x | y);
      OP_XOR:   sc_o_d = x ^ y;
      OP_XNOR:  sc_o_d = ~(x ^ y);
      OP_SHIFT: begin
        if ({1'b0, y} >= SHIFT_LIM) begin
          sc_o_d = {WIDTH{1'b0}};
        end else begin
          sc_o_d = x << y;
        end
      end
      OP_ADD: begin
        sc_o_d     = sum_d[WIDTH-1:0];
        sc_carry_d = sum_d[WIDTH];
      end
      OP_SUB: begin
        sc_o_d     = x - y;
        sc_carry_d = (x < y);
      end
      OP_MUL:   sc_o_d = {WIDTH{1'b0}};
      OP_DIV:   sc_o_d = {WIDTH{1'b0}};
      default: begin
        sc_o_d   = {WIDTH{1'b0}};
        sc_err_d = 1'b1;
      end
    endcase
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    if (y_q[cnt_q]) begin
      acc_d = acc_q + ({{WIDTH{1'b0}}, x_q} << cnt_q);
    end else begin
      acc_d = acc_q;
    end
    // The partial remainder always ends below 2^WIDTH, so the low bits of the
    // difference are exact. A zero divisor makes every step subtract zero.
    // The quotient then fills with ones and the remainder collects x.
    rem_sh_d = {rem_q, quo_q[WIDTH-1]};
    if (rem_sh_d >= {1'b0, y_q}) begin
      rem_d = rem_sh_d[WIDTH-1:0] - y_q;
      quo_d = (quo_q << 1) | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rem_d = rem_sh_d[WIDTH-1:0];
      quo_d = quo_q << 1;
    end
  end

  // Control FSM with working registers and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= {WIDTH{1'b0}};
      y_q         <= {WIDTH{1'b0}};
      op_q        <= 4'b0000;
      cnt_q       <= {CW{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      o_q         <= {WIDTH{1'b0}};
      product_q   <= {(2*WIDTH){1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            x_q         <= x;
            y_q         <= y;
            op_q        <= opcode;
            cnt_q       <= {CW{1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            quo_q       <= x;
            rem_q       <= {WIDTH{1'b0}};
            req_ready_q <= 1'b0;
            if ((opcode == OP_MUL) || (opcode == OP_DIV)) begin
              state_q <= S_EXEC;
            end else begin
              o_q         <= sc_o_d;
              product_q   <= {(2*WIDTH){1'b0}};
              remainder_q <= {WIDTH{1'b0}};
              carry_q     <= sc_carry_d;
              zero_q      <= (sc_o_d == {WIDTH{1'b0}});
              err_q       <= sc_err_d;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q + CW'(1);
          acc_q <= acc_d;
          quo_q <= quo_d;
          rem_q <= rem_d;
          if (cnt_q == CNT_LAST) begin
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_DONE;
            if (op_q == OP_MUL) begin
              o_q         <= acc_d[WIDTH-1:0];
              product_q   <= acc_d;
              remainder_q <= {WIDTH{1'b0}};
              zero_q      <= (acc_d == {(2*WIDTH){1'b0}});
              err_q       <= 1'b0;
            end else begin
              o_q         <= quo_d;
              product_q   <= {(2*WIDTH){1'b0}};
              remainder_q <= rem_d;
              zero_q      <= (quo_d == {WIDTH{1'b0}});
              err_q       <= (y_q == {WIDTH{1'b0}});
            end
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign o         = o_q;
  assign product   = product_q;
  assign remainder = remainder_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule
